// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares the single memory bus between icache and dcache, one burst at a time.
// Optional macro DCACHE_PRIORITY_EN: dcache always wins simultaneous requests (fixed priority).
module cache_bus_arbiter #(
   parameter int WORDSIZE = 64,
   parameter int TAGWIDTH = 13,
   parameter int BEATS    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ic_reqcyc,
   input  logic [WORDSIZE-1:0] ic_req,
   input  logic [TAGWIDTH-1:0] ic_reqtag,
   output logic                ic_reqack,
   output logic                ic_respcyc,
   output logic [WORDSIZE-1:0] ic_resp,
   output logic [TAGWIDTH-1:0] ic_resptag,
   input  logic                ic_respack,
   input  logic                dc_reqcyc,
   input  logic [WORDSIZE-1:0] dc_req,
   input  logic [TAGWIDTH-1:0] dc_reqtag,
   output logic                dc_reqack,
   output logic                dc_respcyc,
   output logic [WORDSIZE-1:0] dc_resp,
   output logic [TAGWIDTH-1:0] dc_resptag,
   input  logic                dc_respack,
   output logic                bus_reqcyc,
   output logic [WORDSIZE-1:0] bus_req,
   output logic [TAGWIDTH-1:0] bus_reqtag,
   input  logic                bus_reqack,
   input  logic                bus_respcyc,
   input  logic [WORDSIZE-1:0] bus_resp,
   input  logic [TAGWIDTH-1:0] bus_resptag,
   output logic                bus_respack
);

   localparam int CNTW = $clog2(BEATS) + 1;
   localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);
   localparam logic GNT_IC = 1'b0;
   localparam logic GNT_DC = 1'b1;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [CNTW-1:0]       beat_cnt_q, beat_cnt_d;
   logic                  bus_reqcyc_q, bus_reqcyc_d;
   logic [WORDSIZE-1:0]   bus_req_q, bus_req_d;
   logic [TAGWIDTH-1:0]   bus_reqtag_q, bus_reqtag_d;
   logic                  ic_reqack_q, ic_reqack_d;
   logic                  dc_reqack_q, dc_reqack_d;
   logic                  in_resp;
   logic                  beat_done;
   logic                  pick_dc;

`ifdef DCACHE_PRIORITY_EN
   assign pick_dc = dc_reqcyc;
`else
   // Round-robin: dcache wins a tie only when the icache had the previous grant.
   assign pick_dc = dc_reqcyc && (!ic_reqcyc || (last_grant_q == GNT_IC));
`endif

   // Reset kills the response path in the same cycle it is asserted.
   assign in_resp = (state_q == RESP) && !reset;

   always_comb begin
      ic_respcyc  = 1'b0;
      ic_resp     = '0;
      ic_resptag  = '0;
      dc_respcyc  = 1'b0;
      dc_resp     = '0;
      dc_resptag  = '0;
      bus_respack = 1'b0;
      if (in_resp) begin
         if (grant_q == GNT_DC) begin
            dc_respcyc  = bus_respcyc;
            dc_resp     = bus_resp;
            dc_resptag  = bus_resptag;
            bus_respack = dc_respack;
         end else begin
            ic_respcyc  = bus_respcyc;
            ic_resp     = bus_resp;
            ic_resptag  = bus_resptag;
            bus_respack = ic_respack;
         end
      end
   end

   assign beat_done = in_resp && bus_respcyc && bus_respack;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      bus_reqcyc_d = bus_reqcyc_q;
      bus_req_d    = bus_req_q;
      bus_reqtag_d = bus_reqtag_q;
      ic_reqack_d  = 1'b0;
      dc_reqack_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ic_reqcyc || dc_reqcyc) begin
               grant_d      = pick_dc ? GNT_DC : GNT_IC;
               last_grant_d = pick_dc ? GNT_DC : GNT_IC;
               bus_req_d    = pick_dc ? dc_req : ic_req;
               bus_reqtag_d = pick_dc ? dc_reqtag : ic_reqtag;
               bus_reqcyc_d = 1'b1;
               state_d      = REQ;
            end
         end
         REQ: begin
            if (bus_reqack) begin
               bus_reqcyc_d = 1'b0;
               ic_reqack_d  = (grant_q == GNT_IC);
               dc_reqack_d  = (grant_q == GNT_DC);
               state_d      = RESP;
            end
         end
         RESP: begin
            if (beat_done) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNTW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= GNT_IC;
         last_grant_q <= GNT_DC;
         beat_cnt_q   <= '0;
         bus_reqcyc_q <= 1'b0;
         bus_req_q    <= '0;
         bus_reqtag_q <= '0;
         ic_reqack_q  <= 1'b0;
         dc_reqack_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         bus_reqcyc_q <= bus_reqcyc_d;
         bus_req_q    <= bus_req_d;
         bus_reqtag_q <= bus_reqtag_d;
         ic_reqack_q  <= ic_reqack_d;
         dc_reqack_q  <= dc_reqack_d;
      end
   end

   assign bus_reqcyc = bus_reqcyc_q && !reset;
   assign bus_req    = bus_req_q;
   assign bus_reqtag = bus_reqtag_q;
   assign ic_reqack  = ic_reqack_q;
   assign dc_reqack  = dc_reqack_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: scoreboard queues of expected grants and response beats.
// Honours DCACHE_PRIORITY_EN when choosing the expected grant order under contention.
module tb_cache_bus_arbiter;

   localparam int WS = 64;
   localparam int TW = 13;
   localparam int NB = 8;
   localparam bit IC = 1'b0;
   localparam bit DC = 1'b1;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_reqcyc, ic_reqack, ic_respcyc, ic_respack;
   logic [WS-1:0] ic_req, ic_resp;
   logic [TW-1:0] ic_reqtag, ic_resptag;
   logic          dc_reqcyc, dc_reqack, dc_respcyc, dc_respack;
   logic [WS-1:0] dc_req, dc_resp;
   logic [TW-1:0] dc_reqtag, dc_resptag;
   logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
   logic [WS-1:0] bus_req, bus_resp;
   logic [TW-1:0] bus_reqtag, bus_resptag;

   cache_bus_arbiter #(.WORDSIZE(WS), .TAGWIDTH(TW), .BEATS(NB)) dut (
      .clk(clk), .reset(reset),
      .ic_reqcyc(ic_reqcyc), .ic_req(ic_req), .ic_reqtag(ic_reqtag), .ic_reqack(ic_reqack),
      .ic_respcyc(ic_respcyc), .ic_resp(ic_resp), .ic_resptag(ic_resptag), .ic_respack(ic_respack),
      .dc_reqcyc(dc_reqcyc), .dc_req(dc_req), .dc_reqtag(dc_reqtag), .dc_reqack(dc_reqack),
      .dc_respcyc(dc_respcyc), .dc_resp(dc_resp), .dc_resptag(dc_resptag), .dc_respack(dc_respack),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
      .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
   );

   always #5 clk = ~clk;

   typedef struct { bit who; logic [WS-1:0] addr; logic [TW-1:0] tag; } req_t;
   typedef struct { bit who; logic [WS-1:0] data; logic [TW-1:0] tag; } beat_t;

   req_t  req_q[$];
   beat_t beat_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   task automatic abort(input string name);
      checks++;
      errors++;
      $display("FAIL %s observed=timeout expected=event", name);
      finish_run();
   endtask

   task automatic check_quiet(input string name);
      chk({name, "_bus_reqcyc"}, 64'(bus_reqcyc), 64'(0));
      chk({name, "_bus_req"}, bus_req, 64'(0));
      chk({name, "_reqacks"}, 64'({ic_reqack, dc_reqack}), 64'(0));
      chk({name, "_respcycs"}, 64'({ic_respcyc, dc_respcyc}), 64'(0));
      chk({name, "_resps"}, ic_resp | dc_resp, 64'(0));
      chk({name, "_bus_respack"}, 64'(bus_respack), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      ic_reqcyc = 1'b0; dc_reqcyc = 1'b0;
      bus_reqack = 1'b0; bus_respcyc = 1'b0; ic_respack = 1'b0; dc_respack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_quiet("reset");
   endtask

   task automatic expect_req(input bit who, input logic [WS-1:0] addr, input logic [TW-1:0] tag);
      req_t e;
      e.who = who; e.addr = addr; e.tag = tag;
      req_q.push_back(e);
   endtask

   task automatic raise(input bit who, input logic [WS-1:0] addr, input logic [TW-1:0] tag);
      @(negedge clk);
      if (who == DC) begin
         dc_reqcyc = 1'b1; dc_req = addr; dc_reqtag = tag;
      end else begin
         ic_reqcyc = 1'b1; ic_req = addr; ic_reqtag = tag;
      end
      expect_req(who, addr, tag);
      #1;
      chk("bus_reqcyc_before_grant", 64'(bus_reqcyc), 64'(0));
   endtask

   // bus_reqcyc must show up exactly one cycle after the arbiter can see the request
   task automatic wait_grant(input string name);
      int n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         n++;
         if (bus_reqcyc) break;
      end
      if (!bus_reqcyc) abort({name, "_wait_bus_reqcyc"});
      chk({name, "_grant_latency"}, 64'(n), 64'(1));
   endtask

   task automatic grant_cycle(input string name, input bit drop_self, input bit drop_other,
                              output req_t e);
      if (req_q.size() == 0) abort({name, "_req_queue_empty"});
      e = req_q.pop_front();
      chk({name, "_bus_req"}, bus_req, e.addr);
      chk({name, "_bus_reqtag"}, 64'(bus_reqtag), 64'(e.tag));
      chk({name, "_reqack_early"}, 64'({ic_reqack, dc_reqack}), 64'(0));
      bus_reqack = 1'b1;
      @(negedge clk);
      bus_reqack = 1'b0;
      #1;
      chk({name, "_ic_reqack"}, 64'(ic_reqack), 64'(e.who == IC));
      chk({name, "_dc_reqack"}, 64'(dc_reqack), 64'(e.who == DC));
      chk({name, "_bus_reqcyc_off"}, 64'(bus_reqcyc), 64'(0));
      if (e.who == IC) begin
         if (drop_self) ic_reqcyc = 1'b0;
         else begin ic_req = ic_req + 64'h40; ic_reqtag = ic_reqtag + TW'(1); end
         if (drop_other) dc_reqcyc = 1'b0;
      end else begin
         if (drop_self) dc_reqcyc = 1'b0;
         else begin dc_req = dc_req + 64'h40; dc_reqtag = dc_reqtag + TW'(1); end
         if (drop_other) ic_reqcyc = 1'b0;
      end
   endtask

   // late_at raises a dcache request mid-burst; reset_at aborts the burst at that beat
   task automatic burst(input string name, input bit who, input logic [TW-1:0] tag,
                        input logic [WS-1:0] base, input int stall_at, input int late_at,
                        input int reset_at);
      beat_t b_e;
      for (int b = 0; b < NB; b++) begin
         @(negedge clk);
         if (b == late_at) begin
            dc_reqcyc = 1'b1; dc_req = 64'h4000; dc_reqtag = TW'(8);
            expect_req(DC, 64'h4000, TW'(8));
         end
         if (b == stall_at) begin
            for (int s = 0; s < 3; s++) begin
               bus_respcyc = 1'b1; bus_resp = 64'hBAD0 + 64'(s); bus_resptag = tag;
               ic_respack = 1'b0; dc_respack = 1'b0;
               #1;
               chk({name, "_stall_bus_respack"}, 64'(bus_respack), 64'(0));
               chk({name, "_stall_respcyc"}, 64'(who == DC ? dc_respcyc : ic_respcyc), 64'(1));
               @(negedge clk);
            end
         end
         if (b == reset_at) begin
            reset = 1'b1;
            bus_respcyc = 1'b1; bus_resp = base + 64'(b); bus_resptag = tag;
            ic_respack = (who == IC); dc_respack = (who == DC);
            #1;
            chk({name, "_rst_respcycs"}, 64'({ic_respcyc, dc_respcyc}), 64'(0));
            chk({name, "_rst_bus_respack"}, 64'(bus_respack), 64'(0));
            chk({name, "_rst_bus_reqcyc"}, 64'(bus_reqcyc), 64'(0));
            return;
         end
         bus_respcyc = 1'b1; bus_resp = base + 64'(b); bus_resptag = tag;
         ic_respack = (who == IC); dc_respack = (who == DC);
         b_e.who = who; b_e.data = base + 64'(b); b_e.tag = tag;
         beat_q.push_back(b_e);
         #1;
         b_e = beat_q.pop_front();
         $display("%s beat %0d who=%0d data=0x%0h tag=0x%0h", name, b, b_e.who, b_e.data, b_e.tag);
         if (b_e.who == DC) begin
            chk({name, "_dc_respcyc"}, 64'(dc_respcyc), 64'(1));
            chk({name, "_dc_resp"}, dc_resp, b_e.data);
            chk({name, "_dc_resptag"}, 64'(dc_resptag), 64'(b_e.tag));
            chk({name, "_ic_idle"}, 64'(ic_respcyc) | ic_resp, 64'(0));
         end else begin
            chk({name, "_ic_respcyc"}, 64'(ic_respcyc), 64'(1));
            chk({name, "_ic_resp"}, ic_resp, b_e.data);
            chk({name, "_ic_resptag"}, 64'(ic_resptag), 64'(b_e.tag));
            chk({name, "_dc_idle"}, 64'(dc_respcyc) | dc_resp, 64'(0));
         end
         chk({name, "_bus_respack"}, 64'(bus_respack), 64'(1));
         chk({name, "_reqacks_in_burst"}, 64'({ic_reqack, dc_reqack}), 64'(0));
      end
      // Burst is over: a stray beat must no longer be forwarded or acked.
      @(negedge clk);
      bus_resp = 64'hDEAD;
      #1;
      chk({name, "_end_respcycs"}, 64'({ic_respcyc, dc_respcyc}), 64'(0));
      chk({name, "_end_bus_respack"}, 64'(bus_respack), 64'(0));
      bus_respcyc = 1'b0; ic_respack = 1'b0; dc_respack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_t e;
      bit   exp_who;
      bit   drop_self;
      reset = 1'b1;
      ic_reqcyc = 1'b0; ic_req = '0; ic_reqtag = '0; ic_respack = 1'b0;
      dc_reqcyc = 1'b0; dc_req = '0; dc_reqtag = '0; dc_respack = 1'b0;
      bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;

      do_reset();

      // Single icache transaction
      raise(IC, 64'h1000, TW'(5));
      wait_grant("t1");
      grant_cycle("t1", 1'b1, 1'b0, e);
      burst("t1", e.who, e.tag, 64'hA0, -1, -1, -1);

      // Mid-burst stall: three unacked cycles do not count as beats
      raise(IC, 64'h2000, TW'(6));
      wait_grant("t2");
      grant_cycle("t2", 1'b1, 1'b0, e);
      burst("t2", e.who, e.tag, 64'hB0, 5, -1, -1);

      // dcache arrives during icache beat 3 and must wait for the whole burst
      raise(IC, 64'h3000, TW'(7));
      wait_grant("t3ic");
      grant_cycle("t3ic", 1'b1, 1'b0, e);
      burst("t3ic", e.who, e.tag, 64'hC0, -1, 3, -1);
      wait_grant("t3dc");
      grant_cycle("t3dc", 1'b1, 1'b0, e);
      burst("t3dc", e.who, e.tag, 64'hD0, -1, -1, -1);

      // Reset at beat 4 aborts the burst; a fresh dcache request is then served
      raise(IC, 64'h5000, TW'(9));
      wait_grant("t4ic");
      grant_cycle("t4ic", 1'b1, 1'b0, e);
      burst("t4ic", e.who, e.tag, 64'hE0, -1, -1, 4);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_quiet("t4_after_reset");
      bus_respcyc = 1'b0; ic_respack = 1'b0; dc_respack = 1'b0;
      raise(DC, 64'h6000, TW'(10));
      wait_grant("t4dc");
      grant_cycle("t4dc", 1'b1, 1'b0, e);
      burst("t4dc", e.who, e.tag, 64'hF0, -1, -1, -1);

      // Both requesting continuously from reset
      do_reset();
      @(negedge clk);
      ic_reqcyc = 1'b1; ic_req = 64'h7000; ic_reqtag = TW'(16);
      dc_reqcyc = 1'b1; dc_req = 64'h8000; dc_reqtag = TW'(32);
      for (int t = 0; t < 4; t++) begin
`ifdef DCACHE_PRIORITY_EN
         exp_who   = (t < 3) ? DC : IC;
         drop_self = (t >= 2);
`else
         exp_who   = (t % 2 == 0) ? IC : DC;
         drop_self = (t == 3);
`endif
         expect_req(exp_who, exp_who == DC ? dc_req : ic_req, exp_who == DC ? dc_reqtag : ic_reqtag);
         wait_grant($sformatf("rr%0d", t));
         grant_cycle($sformatf("rr%0d", t), drop_self, t == 3, e);
         $display("rr%0d granted who=%0d addr=0x%0h", t, e.who, e.addr);
         burst($sformatf("rr%0d", t), e.who, e.tag, 64'h100 * 64'(t + 1), -1, -1, -1);
      end

      chk("req_queue_drained", 64'(req_q.size()), 64'(0));
      chk("beat_queue_drained", 64'(beat_q.size()), 64'(0));
      finish_run();
   end

endmodule
